// File: rtl/glitch_sweep_ctrl.sv
// Glitch sweep sequencer: steps the trigger delay over a programmed range, arms the
// trigger/success detectors per attempt and records the first delay that produced a success.
module glitch_sweep_ctrl #(
  parameter int unsigned TRIG_TIMEOUT  = 32'd48000000,
  parameter int unsigned RESULT_WINDOW = 32'd4800,
  parameter int unsigned GAP_CYCLES    = 32'd4,
  parameter bit          STOP_ON_HIT   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] delay_first,
  input  logic [31:0] delay_last,
  input  logic [31:0] delay_step,
  input  logic        trigger,
  input  logic        success,
  output logic [31:0] delay_cycles,
  output logic        set_delay,
  output logic        trigger_arm,
  output logic        success_arm,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [31:0] hit_delay,
  output logic [15:0] attempts,
  output logic [15:0] timeouts
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD        = 3'd1,
    S_WAIT_TRIG   = 3'd2,
    S_WAIT_RESULT = 3'd3,
    S_GAP         = 3'd4,
    S_NEXT        = 3'd5,
    S_DONE        = 3'd6
  } state_t;

  localparam logic [31:0] TRIG_LAST   = 32'(TRIG_TIMEOUT - 32'd1);
  localparam logic [31:0] RESULT_LAST = 32'(RESULT_WINDOW - 32'd1);
  localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 32'd1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] last_q, last_d;
  logic [31:0] step_q, step_d;
  logic        hit_q, hit_d;
  logic [31:0] hit_delay_q, hit_delay_d;
  logic [15:0] attempts_q, attempts_d;
  logic [15:0] timeouts_q, timeouts_d;
  logic        set_delay_q, trigger_arm_q, success_arm_q, busy_q, done_q;
  logic [32:0] sum_s;
  logic        abort_s;

  // DONE is excluded so a held abort cannot keep re-entering DONE
  assign abort_s = abort && (state_q != S_IDLE) && (state_q != S_DONE);

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    last_d      = last_q;
    step_d      = step_q;
    hit_d       = hit_q;
    hit_delay_d = hit_delay_q;
    attempts_d  = attempts_q;
    timeouts_d  = timeouts_q;
    sum_s       = {1'b0, cur_q} + {1'b0, step_q};
    if (abort_s) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_d       = delay_first;
            last_d      = delay_last;
            step_d      = (delay_step == 32'd0) ? 32'd1 : delay_step;
            hit_d       = 1'b0;
            hit_delay_d = 32'd0;
            attempts_d  = 16'd0;
            timeouts_d  = 16'd0;
            state_d     = (delay_first > delay_last) ? S_DONE : S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          cnt_d   = 32'd0;
          state_d = S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          // a success coincident with the trigger would be lost once WAIT_RESULT re-arms
          if (trigger && success) begin
            hit_d       = 1'b1;
            hit_delay_d = hit_q ? hit_delay_q : cur_q;
            cnt_d       = 32'd0;
            if (STOP_ON_HIT) begin
              attempts_d = sat_inc16(attempts_q);
              state_d    = S_DONE;
            end else begin
              state_d = S_GAP;
            end
          end else if (trigger) begin
            cnt_d   = 32'd0;
            state_d = S_WAIT_RESULT;
          end else if (cnt_q == TRIG_LAST) begin
            timeouts_d = sat_inc16(timeouts_q);
            cnt_d      = 32'd0;
            state_d    = S_GAP;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_WAIT_RESULT: begin
          if (success) begin
            hit_d       = 1'b1;
            hit_delay_d = hit_q ? hit_delay_q : cur_q;
            cnt_d       = 32'd0;
            if (STOP_ON_HIT) begin
              attempts_d = sat_inc16(attempts_q);
              state_d    = S_DONE;
            end else begin
              state_d = S_GAP;
            end
          end else if (cnt_q == RESULT_LAST) begin
            cnt_d   = 32'd0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            attempts_d = sat_inc16(attempts_q);
            state_d    = S_NEXT;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_NEXT: begin
          // 33-bit sum so a carry out of the top counts as past the end
          if (sum_s > {1'b0, last_q}) begin
            state_d = S_DONE;
          end else begin
            cur_d   = sum_s[31:0];
            state_d = S_LOAD;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 32'd0;
      cur_q         <= 32'd0;
      last_q        <= 32'd0;
      step_q        <= 32'd0;
      hit_q         <= 1'b0;
      hit_delay_q   <= 32'd0;
      attempts_q    <= 16'd0;
      timeouts_q    <= 16'd0;
      set_delay_q   <= 1'b0;
      trigger_arm_q <= 1'b0;
      success_arm_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      step_q        <= step_d;
      hit_q         <= hit_d;
      hit_delay_q   <= hit_delay_d;
      attempts_q    <= attempts_d;
      timeouts_q    <= timeouts_d;
      set_delay_q   <= (state_d == S_LOAD);
      trigger_arm_q <= (state_d == S_WAIT_TRIG);
      success_arm_q <= (state_d == S_WAIT_TRIG) || (state_d == S_WAIT_RESULT);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_DONE);
    end
  end

  assign delay_cycles = cur_q;
  assign set_delay    = set_delay_q;
  assign trigger_arm  = trigger_arm_q;
  assign success_arm  = success_arm_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign hit          = hit_q;
  assign hit_delay    = hit_delay_q;
  assign attempts     = attempts_q;
  assign timeouts     = timeouts_q;

endmodule

// File: doc/glitch_sweep_ctrl.md
# glitch_sweep_ctrl

Sequencer that drives the glitch chain's control side and consumes its status side. For each delay value in a programmed range it loads the trigger delay, arms the trigger and success edge detectors, waits for the target's trigger, and then watches a bounded window for a success pulse. It sits between the host/command logic and the `detect_edge`/`trigger_delay` instances, and produces the `delay_cycles`, `set_delay`, `trigger_arm` and `success_arm` nets.

## Interface
- `TRIG_TIMEOUT`, 48000000: max clk cycles to wait for `trigger` per attempt (≥1).
- `RESULT_WINDOW`, 4800: clk cycles after trigger during which `success` counts (≥1).
- `GAP_CYCLES`, 4: idle cycles, both arms low, between attempts (≥2, covers the 2-cycle detector pulse).
- `STOP_ON_HIT`, 1: 1 = end the sweep at the first success; 0 = run the full range.

Ports:
- `clk` in 1: system clock, 48 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle sweep request, sampled only in IDLE.
- `abort` in 1: level; forces DONE from any non-IDLE state.
- `delay_first` in 32: first delay value.
- `delay_last` in 32: last delay value, inclusive.
- `delay_step` in 32: increment; 0 is treated as 1.
- `trigger` in 1: pulse from the trigger detector.
- `success` in 1: pulse from the success detector.
- `delay_cycles` out 32: value presented to `trigger_delay`.
- `set_delay` out 1: one-cycle load strobe.
- `trigger_arm` out 1: arms the trigger detector.
- `success_arm` out 1: arms the success detector.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at sweep end.
- `hit` out 1: sticky; set when a success is seen; cleared on `start`.
- `hit_delay` out 32: `delay_cycles` of the first hit.
- `attempts` out 16: number of completed attempts, saturating at 0xFFFF; cleared on `start`.
- `timeouts` out 16: number of attempts that saw no trigger, saturating; cleared on `start`.

## Operation
- States are IDLE, LOAD, WAIT_TRIG, WAIT_RESULT, GAP, NEXT and DONE.
- **IDLE:** on `start`:
  - Latch `delay_first`, `delay_last` and the effective step.
  - Clear `hit`, `hit_delay`, `attempts` and `timeouts`.
  - If `delay_first > delay_last`, go to DONE with zero attempts. Otherwise go to LOAD.
- **LOAD:** one cycle. `delay_cycles` = current value and `set_delay` = 1. Go to WAIT_TRIG.
- **WAIT_TRIG:**
  - `trigger_arm` = `success_arm` = 1. The timeout counter starts at 0.
  - `trigger` high → WAIT_RESULT.
  - Counter reaches `TRIG_TIMEOUT`-1 with no trigger → increment `timeouts` and go to GAP.
- **WAIT_RESULT:**
  - `trigger_arm` = 0, `success_arm` = 1. The window counter starts at 0.
  - `success` high → hit.
  - Counter reaches `RESULT_WINDOW`-1 → GAP (miss).
- **On a hit:**
  - If `hit` is 0, capture `hit_delay`. Set `hit`.
  - Go to GAP, or to DONE if `STOP_ON_HIT`=1 (the attempt is counted in both cases).
- **GAP:** both arms 0 for `GAP_CYCLES`. Increment `attempts`, then go to NEXT.
- **NEXT:**
  - Compute the next delay as a 33-bit sum of current + step.
  - If the sum exceeds `delay_last` (including the 33-bit carry case), go to DONE. Otherwise store it and go to LOAD.
- **DONE:** `done` = 1 for one cycle, then IDLE. All results hold until the next `start`.
- **abort:** from any non-IDLE state, go to DONE next cycle with arms low. The current attempt is not counted.
- **Simultaneous events:**
  - `trigger` and `success` in the same WAIT_TRIG cycle: the success is not lost. It is recorded as a hit on the transition and the FSM bypasses WAIT_RESULT.
  - `success` during WAIT_TRIG without `trigger`: ignored.
  - `start` while busy: ignored.
- **Range inputs:** `delay_*` inputs are sampled only at `start`. Changes mid-sweep have no effect.

## Timing
- **Reset values:** state IDLE; all outputs 0 (`delay_cycles` 0, `hit_delay` 0, counters 0).
- **Registered outputs:** all outputs are registered and change on `posedge clk`.
- **Start latency:** `start` at cycle N → `set_delay`=1 and valid `delay_cycles` at N+1, arms high at N+2.
- **Trigger response:** trigger seen at cycle T → `trigger_arm` low at T+1.
- **Hit timing:** `hit` and `hit_delay` are visible at H+1 for a success seen at cycle H.
- **Per-attempt cost (no timeout):** 1 (LOAD) + trigger wait + ≤`RESULT_WINDOW` + `GAP_CYCLES` + 1 (NEXT).
- **Boundaries:**
  - `delay_first == delay_last` → exactly one attempt.
  - `delay_last = 0xFFFFFFFF` with step 1 → the final value 0xFFFFFFFF is attempted, then DONE with no wrap.
- **Reset mid-operation:** asynchronous return to reset values; `done` does not pulse.

## Test plan
- **Basic sweep:** first=10, last=14, step=2; trigger 20 cycles after each arm; no success → `set_delay` pulses with `delay_cycles` 10, 12, 14; `attempts`=3, `hit`=0; `done` pulses once.
- **Stop on hit:** same range, success pulse 5 cycles after the trigger on the delay=12 attempt, `STOP_ON_HIT`=1 → `hit`=1, `hit_delay`=12, `attempts`=2; no LOAD for 14.
- **Timeout:** `TRIG_TIMEOUT`=8, trigger never asserted, range 0..1 → `timeouts`=2, `attempts`=2; `trigger_arm` high exactly 8 cycles per attempt.
- **Edge ranges:** first=5, last=4 → `done` at start+1 with `attempts`=0. first=last=0xFFFFFFFF, step=0 → one attempt, then DONE with no wrap.
- **Same-cycle trigger and success:** trigger and success in the same cycle → recorded as a hit. A success arriving before any trigger → ignored.
- **Abort and reset:** `abort` asserted in WAIT_RESULT → `done` next cycle, arms 0, current attempt not counted. `rst` pulsed mid-sweep → all outputs 0 immediately, with no `done` pulse.
